// File: rtl/sort_queue.sv
// rtl/sort_queue.sv - registered insertion-sort priority queue, head at slot 0
// Each slot decides its next value locally from the new entry and its neighbours.
module sort_queue #(
  parameter int DATA_W     = 12,
  parameter int KEY_W      = 8,
  parameter int DEPTH      = 8,
  parameter bit DESCENDING = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] slot_q [DEPTH];
  logic [DATA_W-1:0] slot_d [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [CW-1:0]     count_q, count_d;

  // Extended by one always-invalid slot so a pop can shift without a range special case.
  logic [DATA_W-1:0] slot_ext [DEPTH+1];
  logic [DEPTH:0]    valid_ext;
  logic [DATA_W-1:0] base_data [DEPTH];
  logic [DEPTH-1:0]  base_valid;
  logic [DEPTH-1:0]  ins_at;

  logic              push, pop;
  logic [KEY_W-1:0]  new_key, base_key;
  logic              prev_ins, prev_bv;
  logic [DATA_W-1:0] prev_data;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = ~full;
  assign out_valid = valid_q[0];
  assign out_data  = valid_q[0] ? slot_q[0] : '0;
  assign count     = count_q;

  assign push    = in_valid & ~full;
  assign pop     = valid_q[0] & out_ready;
  assign new_key = in_data[DATA_W-1 -: KEY_W];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_ext[i]  = slot_q[i];
      valid_ext[i] = valid_q[i];
    end
    slot_ext[DEPTH]  = '0;
    valid_ext[DEPTH] = 1'b0;

    // Pop happens first; insertion is then evaluated against the shifted array.
    base_key = '0;
    for (int i = 0; i < DEPTH; i++) begin
      base_data[i]  = pop ? slot_ext[i+1]  : slot_ext[i];
      base_valid[i] = pop ? valid_ext[i+1] : valid_ext[i];
      base_key      = base_data[i][DATA_W-1 -: KEY_W];
      // Strict compare keeps ties FIFO: the new entry goes after equal keys.
      ins_at[i] = ~base_valid[i] |
                  (DESCENDING ? (base_key < new_key) : (base_key > new_key));
    end

    prev_ins  = 1'b0;
    prev_bv   = 1'b1;
    prev_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_d[i]  = base_data[i];
      valid_d[i] = base_valid[i] | (push & prev_bv);
      if (push && ins_at[i]) begin
        slot_d[i] = prev_ins ? prev_data : in_data;
      end
      prev_ins  = ins_at[i];
      prev_bv   = base_valid[i];
      prev_data = base_data[i];
    end

    count_d = count_q + CW'(push) - CW'(pop);

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_d[i] = slot_q[i];
      end
      valid_d = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
      end
      valid_q <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= slot_d[i];
      end
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_sort_queue.sv
// tb/tb_sort_queue.sv - directed and model-based bench for sort_queue
// A descending and an ascending instance share the same stimulus.
module tb_sort_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [11:0] in_data = '0;

  logic        d_in_ready, d_out_valid, d_full, d_empty;
  logic [11:0] d_out_data;
  logic [3:0]  d_count;
  logic        a_in_ready, a_out_valid, a_full, a_empty;
  logic [11:0] a_out_data;
  logic [3:0]  a_count;

  int tests_run = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sort_queue #(.DATA_W(12), .KEY_W(8), .DEPTH(8), .DESCENDING(1'b1)) u_desc (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(d_in_ready), .in_data(in_data),
    .out_valid(d_out_valid), .out_ready(out_ready), .out_data(d_out_data),
    .count(d_count), .full(d_full), .empty(d_empty)
  );

  sort_queue #(.DATA_W(12), .KEY_W(8), .DEPTH(8), .DESCENDING(1'b0)) u_asc (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .count(a_count), .full(a_full), .empty(a_empty)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic v, input logic [11:0] d, input logic r, input logic f);
    in_valid = v; in_data = d; out_ready = r; flush = f;
    tick();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic do_flush();
    cycle(1'b0, 12'h0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    tests_run++;
    if ({d_count, d_empty, d_full, d_in_ready, d_out_valid, d_out_data} !== {4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000}) begin
      fails++;
      $display("FAIL reset_state: got cnt=%0d e=%b f=%b ir=%b ov=%b od=%h, want 0 1 0 1 0 000",
               d_count, d_empty, d_full, d_in_ready, d_out_valid, d_out_data);
    end
  endtask

  task automatic test_order();
    logic [11:0] exp_pop [3];
    exp_pop[0] = 12'h802; exp_pop[1] = 12'h403; exp_pop[2] = 12'h101;
    cycle(1'b1, 12'h101, 1'b0, 1'b0);
    tests_run++;
    if (d_out_data !== 12'h101) begin
      fails++; $display("FAIL order_first_head: got %h want 101", d_out_data);
    end
    cycle(1'b1, 12'h802, 1'b0, 1'b0);
    cycle(1'b1, 12'h403, 1'b0, 1'b0);
    tests_run++;
    if (d_count !== 4'd3) begin
      fails++; $display("FAIL order_count: got %0d want 3", d_count);
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (d_out_data !== exp_pop[i] || d_out_valid !== 1'b1) begin
        fails++; $display("FAIL order_pop%0d: got %h ov=%b want %h", i, d_out_data, d_out_valid, exp_pop[i]);
      end
      cycle(1'b0, 12'h0, 1'b1, 1'b0);
    end
    tests_run++;
    if ({d_empty, d_out_valid, d_out_data} !== {1'b1, 1'b0, 12'h000}) begin
      fails++; $display("FAIL order_empty: got e=%b ov=%b od=%h want 1 0 000", d_empty, d_out_valid, d_out_data);
    end
    cycle(1'b0, 12'h0, 1'b1, 1'b0);
    tests_run++;
    if (d_count !== 4'd0) begin
      fails++; $display("FAIL empty_pop_underflow: got %0d want 0", d_count);
    end
  endtask

  task automatic test_ties();
    logic [11:0] exp_pop [3];
    exp_pop[0] = 12'h551; exp_pop[1] = 12'h552; exp_pop[2] = 12'h553;
    cycle(1'b1, 12'h551, 1'b0, 1'b0);
    cycle(1'b1, 12'h552, 1'b0, 1'b0);
    cycle(1'b1, 12'h553, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (d_out_data !== exp_pop[i]) begin
        fails++; $display("FAIL ties_pop%0d: got %h want %h", i, d_out_data, exp_pop[i]);
      end
      cycle(1'b0, 12'h0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_full();
    for (int i = 1; i <= 8; i++) cycle(1'b1, 12'(i * 16 + 1), 1'b0, 1'b0);
    tests_run++;
    if ({d_full, d_in_ready, d_count, d_out_data} !== {1'b1, 1'b0, 4'd8, 12'h081}) begin
      fails++; $display("FAIL full_flags: got f=%b ir=%b cnt=%0d od=%h want 1 0 8 081", d_full, d_in_ready, d_count, d_out_data);
    end
    cycle(1'b1, 12'hFF1, 1'b0, 1'b0);
    tests_run++;
    if (d_count !== 4'd8 || d_out_data !== 12'h081) begin
      fails++; $display("FAIL full_push_dropped: got cnt=%0d od=%h want 8 081", d_count, d_out_data);
    end
    cycle(1'b1, 12'hFE1, 1'b1, 1'b0);
    tests_run++;
    if ({d_count, d_out_data, d_in_ready} !== {4'd7, 12'h071, 1'b1}) begin
      fails++; $display("FAIL full_pop_push: got cnt=%0d od=%h ir=%b want 7 071 1", d_count, d_out_data, d_in_ready);
    end
    do_flush();
  endtask

  task automatic test_push_pop();
    cycle(1'b1, 12'h901, 1'b0, 1'b0);
    cycle(1'b1, 12'h502, 1'b0, 1'b0);
    cycle(1'b1, 12'h203, 1'b0, 1'b0);
    cycle(1'b1, 12'h604, 1'b1, 1'b0);
    tests_run++;
    if (d_out_data !== 12'h604 || d_count !== 4'd3) begin
      fails++; $display("FAIL pushpop_head: got od=%h cnt=%0d want 604 3", d_out_data, d_count);
    end
    cycle(1'b0, 12'h0, 1'b1, 1'b0);
    tests_run++;
    if (d_out_data !== 12'h502) begin
      fails++; $display("FAIL pushpop_second: got %h want 502", d_out_data);
    end
    cycle(1'b0, 12'h0, 1'b1, 1'b0);
    tests_run++;
    if (d_out_data !== 12'h203) begin
      fails++; $display("FAIL pushpop_third: got %h want 203", d_out_data);
    end
    do_flush();
    cycle(1'b1, 12'h301, 1'b0, 1'b0);
    cycle(1'b1, 12'h102, 1'b1, 1'b0);
    tests_run++;
    if (d_out_data !== 12'h102 || d_count !== 4'd1) begin
      fails++; $display("FAIL pushpop_single: got od=%h cnt=%0d want 102 1", d_out_data, d_count);
    end
    do_flush();
  endtask

  task automatic test_ascending();
    logic [11:0] exp_pop [3];
    exp_pop[0] = 12'h052; exp_pop[1] = 12'h301; exp_pop[2] = 12'hF03;
    do_flush();
    cycle(1'b1, 12'h301, 1'b0, 1'b0);
    cycle(1'b1, 12'h052, 1'b0, 1'b0);
    cycle(1'b1, 12'hF03, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (a_out_data !== exp_pop[i]) begin
        fails++; $display("FAIL asc_pop%0d: got %h want %h", i, a_out_data, exp_pop[i]);
      end
      cycle(1'b0, 12'h0, 1'b1, 1'b0);
    end
    tests_run++;
    if (a_empty !== 1'b1) begin
      fails++; $display("FAIL asc_empty: got %b want 1", a_empty);
    end
    do_flush();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) cycle(1'b1, 12'(i * 32 + 5), 1'b0, 1'b0);
    tests_run++;
    if (d_count !== 4'd5) begin
      fails++; $display("FAIL flush_precount: got %0d want 5", d_count);
    end
    cycle(1'b1, 12'hEEE, 1'b1, 1'b1);
    tests_run++;
    if ({d_count, d_empty, d_out_valid, d_out_data} !== {4'd0, 1'b1, 1'b0, 12'h000}) begin
      fails++; $display("FAIL flush_clear: got cnt=%0d e=%b ov=%b od=%h want 0 1 0 000", d_count, d_empty, d_out_valid, d_out_data);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 12'(i * 48 + 7), 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({d_count, d_empty, d_full, d_in_ready, d_out_valid, d_out_data} !== {4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000}) begin
      fails++; $display("FAIL async_reset: got cnt=%0d e=%b f=%b ir=%b ov=%b od=%h want 0 1 0 1 0 000",
                        d_count, d_empty, d_full, d_in_ready, d_out_valid, d_out_data);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_soak();
    logic [11:0] mq [$];
    logic        v, r, f, do_pop, do_push;
    logic [11:0] d;
    int          idx;
    int          bad = 0;
    do_flush();
    mq.delete();
    for (int c = 0; c < 400; c++) begin
      v = ($urandom_range(0, 9) < 6);
      r = ($urandom_range(0, 9) < 4);
      f = ($urandom_range(0, 39) == 0);
      d = {3'($urandom_range(0, 7)), 5'b0, 4'($urandom_range(0, 15))};
      do_pop  = r && (mq.size() > 0);
      do_push = v && (mq.size() < 8);
      if (f) begin
        mq.delete();
      end else begin
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
          idx = mq.size();
          for (int j = 0; j < mq.size(); j++) begin
            if (mq[j][11:4] < d[11:4]) begin
              idx = j;
              break;
            end
          end
          mq.insert(idx, d);
        end
      end
      cycle(v, d, r, f);
      tests_run++;
      if (d_count !== 4'(mq.size()) ||
          d_out_data !== (mq.size() > 0 ? mq[0] : 12'h000)) begin
        fails++;
        if (bad < 5) $display("FAIL soak_cycle%0d: got cnt=%0d od=%h want cnt=%0d od=%h",
                              c, d_count, d_out_data, mq.size(), (mq.size() > 0 ? mq[0] : 12'h000));
        bad++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    #1;
    test_reset();
    tick(); tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_order();
    test_ties();
    test_full();
    test_push_pop();
    test_ascending();
    test_flush();
    test_async_reset();
    test_soak();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
